// File: rtl/montgomery_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : montgomery_pkg
//  Description : Shared definitions for the Montgomery command sequencer:
//                command words, sequencer state encoding and the command
//                lookup indexed by the current command slot.
//  Revision    : 1.0 - initial release
// ============================================================================
package montgomery_pkg;

    localparam logic [31:0] CMD_READ    = 32'h0000_0000;
    localparam logic [31:0] CMD_COMPUTE = 32'h0000_0001;
    localparam logic [31:0] CMD_WRITE   = 32'h0000_0002;

    // Index of the last command of an iteration
    localparam logic [1:0]  IDX_LAST    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

    function automatic logic [31:0] cmd_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_word = CMD_READ;
            2'd1:    cmd_word = CMD_COMPUTE;
            default: cmd_word = CMD_WRITE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : seq_watchdog
//  Description : Free-running up-counter used to detect a hung wrapper.
//                Cleared by clr, advanced by en, expired while all-ones.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset
//                clr     - clear counter (wins over en)
//                en      - count enable
//                expired - counter is at all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
    parameter int TMO_W = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] c_cnt_one = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] r_cnt;

    // Saturates at all-ones so expired cannot wrap back to zero unnoticed
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en && !(&r_cnt)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign expired = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/montgomery_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : montgomery_cmd_sequencer
//  Description : Drives montgomery_wrapper through num_iters iterations of
//                READ -> COMPUTE -> WRITE using the port1 (command) and
//                port2 (completion) handshakes, with a hang watchdog.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start, num_iters    - run request and iteration count
//                busy, done, error   - run status (all registered)
//                iter_count, cmd_idx - progress
//                port1_din/valid/read, port2_valid/read - wrapper handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
module montgomery_cmd_sequencer
    import montgomery_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_iters,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] iter_count,
    output logic [1:0]       cmd_idx,
    output logic [31:0]      port1_din,
    output logic             port1_valid,
    input  logic             port1_read,
    input  logic             port2_valid,
    output logic             port2_read
);

    localparam logic [CNT_W-1:0] c_iter_one = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_iter;
    logic [1:0]       r_cmd_idx;
    logic             r_fin;
    logic             r_busy, r_done, r_error, r_p1_valid, r_p2_read;
    logic [31:0]      r_p1_din;

    logic w_accept, w_cmd_adv, w_iter_adv, w_fin, w_active, w_expired;

    assign w_active = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                      (r_state == ST_ACK);

    seq_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_state_nxt != r_state),
        .en      (w_active),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cmd_adv   = 1'b0;
        w_iter_adv  = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (num_iters == '0) begin
                        w_fin       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: if (port1_read)  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (port2_valid) w_state_nxt = ST_ACK;
            ST_ACK: begin
                if (!port2_valid) begin
                    if (r_cmd_idx != IDX_LAST) begin
                        w_cmd_adv   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_iter_adv = 1'b1;
                        // r_iter < r_count here, so the increment never wraps
                        if (r_iter + c_iter_one == r_count) begin
                            w_fin       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_ISSUE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A hung wrapper overrides any progress made this cycle
        if (w_active && w_expired) begin
            w_state_nxt = ST_ERROR;
            w_cmd_adv   = 1'b0;
            w_iter_adv  = 1'b0;
            w_fin       = 1'b0;
        end
    end

    // Status/handshake outputs are registered images of the current state,
    // so each lags its state change by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_iter     <= '0;
            r_cmd_idx  <= '0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_p1_valid <= 1'b0;
            r_p1_din   <= '0;
            r_p2_read  <= 1'b0;
        end else begin
            r_fin <= w_fin;
            if (w_accept) begin
                r_count   <= num_iters;
                r_iter    <= '0;
                r_cmd_idx <= '0;
            end else if (w_cmd_adv) begin
                r_cmd_idx <= r_cmd_idx + 2'd1;
            end else if (w_iter_adv) begin
                r_cmd_idx <= '0;
                r_iter    <= r_iter + c_iter_one;
            end
            r_busy     <= w_active;
            r_done     <= r_fin;
            r_error    <= (r_state == ST_ERROR);
            r_p1_valid <= (r_state == ST_ISSUE);
            r_p1_din   <= (r_state == ST_ISSUE) ? cmd_word(r_cmd_idx) : 32'h0;
            r_p2_read  <= (r_state == ST_ACK);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign iter_count  = r_iter;
    assign cmd_idx     = r_cmd_idx;
    assign port1_din   = r_p1_din;
    assign port1_valid = r_p1_valid;
    assign port2_read  = r_p2_read;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_montgomery_cmd_sequencer
//  Description : Self-checking bench with a behavioural wrapper model and a
//                command scoreboard for montgomery_cmd_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_cmd_sequencer;
    import montgomery_pkg::*;

    localparam int CNT_W = 16;
    localparam int TMO_W = 4;

    localparam int M_IDLE = 0, M_RD = 1, M_ACC = 2, M_CMP = 3, M_DONE = 4, M_HANG = 5;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [CNT_W-1:0] num_iters;
    logic             busy, done, error;
    logic [CNT_W-1:0] iter_count;
    logic [1:0]       cmd_idx;
    logic [31:0]      port1_din;
    logic             port1_valid, port1_read, port2_valid, port2_read;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    int cyc = 0, done_cnt = 0, cmd_cnt = 0, p1v_cnt = 0;
    int run_cmd = 0, last_cmd_cyc = 0, hang_rd_cyc = 0;
    int rd_dly = 2, cmp_dly = 5, hang_cmd = -1;
    bit chk_gap = 0, m_rst = 1;

    always #5 clk = ~clk;

    montgomery_cmd_sequencer #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_iters   (num_iters),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .iter_count  (iter_count),
        .cmd_idx     (cmd_idx),
        .port1_din   (port1_din),
        .port1_valid (port1_valid),
        .port1_read  (port1_read),
        .port2_valid (port2_valid),
        .port2_read  (port2_read)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wrapper model plus monitors, all sampled on the falling edge
    initial begin : wrapper_model
        int          phase, m_cnt, idx;
        bit          hang_now;
        logic [31:0] exp_cmd;
        phase = M_IDLE; m_cnt = 0; hang_now = 0;
        port1_read = 1'b0; port2_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 0);
            end
            if (port1_valid) p1v_cnt++;
            if (m_rst) begin
                phase = M_IDLE; port1_read = 1'b0; port2_valid = 1'b0;
            end else begin
                case (phase)
                    M_IDLE: begin
                        port1_read = 1'b0;
                        if (port1_valid) begin
                            cmd_cnt++;
                            check("p2r_at_issue", 32'(port2_read), 0);
                            if (chk_gap && run_cmd > 0) check("cmd_gap", 32'(cyc - last_cmd_cyc), 5);
                            last_cmd_cyc = cyc;
                            idx = run_cmd; run_cmd++;
                            hang_now = (idx == hang_cmd);
                            if (sb_q.size() == 0) begin
                                check("sb_extra", 32'(sb_q.size()), 1);
                            end else begin
                                exp_cmd = sb_q.pop_front();
                                check("cmd_word", port1_din, exp_cmd);
                            end
                            if (rd_dly == 0) begin
                                port1_read = 1'b1; phase = M_ACC; hang_rd_cyc = cyc;
                            end else begin
                                m_cnt = rd_dly; phase = M_RD;
                            end
                        end
                    end
                    M_RD: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            port1_read = 1'b1; phase = M_ACC; hang_rd_cyc = cyc;
                        end
                    end
                    M_ACC: begin
                        port1_read = 1'b0;
                        if (hang_now) phase = M_HANG;
                        else if (cmp_dly <= 1) begin
                            port2_valid = 1'b1; phase = M_DONE;
                        end else begin
                            m_cnt = cmp_dly - 1; phase = M_CMP;
                        end
                    end
                    M_CMP: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            port2_valid = 1'b1; phase = M_DONE;
                        end
                    end
                    M_DONE: if (port2_read) begin
                        port2_valid = 1'b0; phase = M_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic start_run(input int n, input bit push);
        @(negedge clk); #1;
        start = 1'b1; num_iters = CNT_W'(n);
        if (push) begin
            run_cmd = 0;
            for (int i = 0; i < n; i++) begin
                sb_q.push_back(CMD_READ);
                sb_q.push_back(CMD_COMPUTE);
                sb_q.push_back(CMD_WRITE);
            end
        end
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        int k;
        k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check("done_seen", 32'(done_cnt != base), 1);
        repeat (3) begin @(negedge clk); #1; end
        check("done_once", 32'(done_cnt - base), 1);
    endtask

    task automatic model_reset();
        m_rst = 1'b1;
        @(negedge clk); #1;
        m_rst = 1'b0;
    endtask

    initial begin : global_bound
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin : stim
        int base, c0, k, d;
        reset = 1'b1; start = 1'b0; num_iters = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0; m_rst = 1'b0;
        @(negedge clk); #1;
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_p1v",   32'(port1_valid), 0);
        check("rst_p2r",   32'(port2_read), 0);
        check("rst_din",   port1_din, 0);
        check("rst_iter",  32'(iter_count), 0);
        check("rst_idx",   32'(cmd_idx), 0);

        // Single iteration, slow wrapper
        base = done_cnt; c0 = cmd_cnt;
        start_run(1, 1);
        check("busy_lag", 32'(busy), 0);
        @(negedge clk); #1;
        check("busy_rise", 32'(busy), 1);
        check("p1v_rise",  32'(port1_valid), 1);
        wait_done(200, base);
        check("t1_iter", 32'(iter_count), 1);
        check("t1_err",  32'(error), 0);
        check("t1_cmds", 32'(cmd_cnt - c0), 3);
        check("t1_sb",   32'(sb_q.size()), 0);

        // Three iterations, num_iters changed mid-run
        base = done_cnt; c0 = cmd_cnt;
        start_run(3, 1);
        repeat (10) @(negedge clk);
        #1 num_iters = CNT_W'(7);
        wait_done(400, base);
        check("t3_iter", 32'(iter_count), 3);
        check("t3_cmds", 32'(cmd_cnt - c0), 9);
        check("t3_sb",   32'(sb_q.size()), 0);

        // Zero count
        base = done_cnt; c0 = p1v_cnt;
        start_run(0, 1);
        check("z_done_lag", 32'(done), 0);
        @(negedge clk); #1;
        check("z_done", 32'(done), 1);
        check("z_busy", 32'(busy), 0);
        @(negedge clk); #1;
        check("z_done_fall", 32'(done), 0);
        repeat (4) @(negedge clk);
        #1;
        check("z_no_p1v", 32'(p1v_cnt - c0), 0);
        check("z_pulses", 32'(done_cnt - base), 1);

        // Hang on the COMPUTE command
        hang_cmd = 1;
        start_run(1, 1);
        k = 0;
        while (!error && k < 100) begin @(negedge clk); #1; k++; end
        check("hang_err", 32'(error), 1);
        d = cyc - hang_rd_cyc;
        check("hang_len", 32'(d >= 16 && d <= 20), 1);
        check("hang_busy", 32'(busy), 0);
        check("hang_p1v",  32'(port1_valid), 0);
        check("hang_p2r",  32'(port2_read), 0);
        check("hang_din",  port1_din, 0);
        check("hang_idx",  32'(cmd_idx), 1);
        sb_q.delete();
        hang_cmd = -1;
        model_reset();
        base = done_cnt;
        start_run(1, 1);
        @(negedge clk); #1;
        check("hang_err_clr", 32'(error), 0);
        wait_done(200, base);
        check("rec_iter", 32'(iter_count), 1);
        check("rec_sb",   32'(sb_q.size()), 0);

        // Reset while a command is being offered
        start_run(1, 1);
        k = 0;
        while (!port1_valid && k < 20) begin @(negedge clk); #1; k++; end
        check("rm_p1v_pre", 32'(port1_valid), 1);
        reset = 1'b1; m_rst = 1'b1;
        @(negedge clk); #1;
        check("rm_flags", 32'({busy, done, error, port1_valid, port2_read}), 0);
        check("rm_din",   port1_din, 0);
        check("rm_iter",  32'(iter_count), 0);
        reset = 1'b0; m_rst = 1'b0;
        sb_q.delete();
        base = done_cnt; c0 = cmd_cnt;
        start_run(2, 1);
        wait_done(300, base);
        check("rm_run_iter", 32'(iter_count), 2);
        check("rm_run_cmds", 32'(cmd_cnt - c0), 6);

        // Fast wrapper: minimum spacing, start while busy ignored
        rd_dly = 0; cmp_dly = 1; chk_gap = 1;
        base = done_cnt; c0 = cmd_cnt;
        start_run(2, 1);
        repeat (4) @(negedge clk);
        start_run(9, 0);
        wait_done(300, base);
        chk_gap = 0;
        check("bb_iter", 32'(iter_count), 2);
        check("bb_cmds", 32'(cmd_cnt - c0), 6);
        check("bb_sb",   32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
